edge_capture_bank: RTL and testbench

- Multi-channel edge detector; next generation of the single-input edge detector.
- Per channel: configurable synchroniser depth, programmable glitch filter, raw rise/fall pulses, per-channel mode select, sticky pending flags, saturating event counters and an aggregated interrupt.
- Sits between asynchronous chip/board status inputs (e.g. hit, interrupt, busy lines) and the register file / interrupt logic.

---
 rtl/edge_capture_pkg.sv | 11 +
 rtl/edge_capture_channel.sv | 99 +++++++++
 rtl/edge_capture_bank.sv | 49 ++++
 tb/tb_edge_capture_bank.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_capture_pkg.sv
// Shared types for the multi-channel edge capture bank.
package edge_capture_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

endpackage

// File: rtl/edge_capture_channel.sv
// One channel: synchroniser, glitch filter, edge pulses, sticky pending flag and
// saturating event counter.
module edge_capture_channel
    import edge_capture_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_BITS = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resn,
    input  logic                   in_i,
    input  edge_mode_t             mode_i,
    input  logic [FILTER_BITS-1:0] filter_len_i,
    input  logic                   pend_clr_i,
    input  logic                   cnt_clr_i,
    output logic                   rise_o,
    output logic                   fall_o,
    output logic                   level_o,
    output logic                   pending_o,
    output logic [COUNT_WIDTH-1:0] count_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   filt_q, filt_d;
    logic [FILTER_BITS-1:0] fcnt_q, fcnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   pending_q, pending_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   s;
    logic                   accept;
    logic                   ev;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], in_i};
        filt_d    = filt_q;
        fcnt_d    = fcnt_q;
        pending_d = pending_q;
        count_d   = count_q;
        accept    = 1'b0;

        // fcnt only increments while below filter_len_i, so it cannot wrap.
        if (s == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q >= filter_len_i) begin
            filt_d = s;
            fcnt_d = '0;
            accept = 1'b1;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end

        rise_d = accept & s;
        fall_d = accept & ~s;
        ev     = (rise_d & mode_i[0]) | (fall_d & mode_i[1]);

        if (ev) begin
            pending_d = 1'b1;
        end else if (pend_clr_i) begin
            pending_d = 1'b0;
        end

        if (cnt_clr_i) begin
            count_d = ev ? COUNT_WIDTH'(1) : '0;
        end else if (ev && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resn) begin
            sync_q    <= '0;
            filt_q    <= 1'b0;
            fcnt_q    <= '0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            pending_q <= 1'b0;
            count_q   <= '0;
        end else begin
            sync_q    <= sync_d;
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign level_o   = filt_q;
    assign pending_o = pending_q;
    assign count_o   = count_q;

endmodule

// File: rtl/edge_capture_bank.sv
// Bank of independent edge capture channels with packed buses and an aggregated
// interrupt.
module edge_capture_bank
    import edge_capture_pkg::*;
#(
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_BITS = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            resn,
    input  logic [CHANNELS-1:0]             in_i,
    input  logic [2*CHANNELS-1:0]           mode_i,
    input  logic [FILTER_BITS-1:0]          filter_len_i,
    input  logic [CHANNELS-1:0]             pend_clr_i,
    input  logic [CHANNELS-1:0]             cnt_clr_i,
    output logic [CHANNELS-1:0]             rise_o,
    output logic [CHANNELS-1:0]             fall_o,
    output logic [CHANNELS-1:0]             level_o,
    output logic [CHANNELS-1:0]             pending_o,
    output logic [CHANNELS*COUNT_WIDTH-1:0] count_o,
    output logic                            irq_o
);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        edge_capture_channel #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_BITS(FILTER_BITS),
            .COUNT_WIDTH(COUNT_WIDTH)
        ) u_chan (
            .clk         (clk),
            .resn        (resn),
            .in_i        (in_i[n]),
            .mode_i      (edge_mode_t'(mode_i[2*n +: 2])),
            .filter_len_i(filter_len_i),
            .pend_clr_i  (pend_clr_i[n]),
            .cnt_clr_i   (cnt_clr_i[n]),
            .rise_o      (rise_o[n]),
            .fall_o      (fall_o[n]),
            .level_o     (level_o[n]),
            .pending_o   (pending_o[n]),
            .count_o     (count_o[n*COUNT_WIDTH +: COUNT_WIDTH])
        );
    end

    assign irq_o = |pending_o;

endmodule

// File: tb/tb_edge_capture_bank.sv
// Directed bench: expected edge pulses go into a scoreboard queue that a negedge
// monitor drains; state outputs are checked inline against hand-computed values.
module tb_edge_capture_bank;

    localparam int unsigned CH = 4;
    localparam int unsigned FB = 4;
    localparam int unsigned CW = 4;

    logic            clk = 1'b0;
    logic            resn;
    logic [CH-1:0]   in_v;
    logic [2*CH-1:0] mode;
    logic [FB-1:0]   flen;
    logic [CH-1:0]   pend_clr;
    logic [CH-1:0]   cnt_clr;
    logic [CH-1:0]   rise_o, fall_o, level_o, pending_o;
    logic [CH*CW-1:0] count_o;
    logic            irq_o;

    typedef struct {
        int unsigned   cyc;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    edge_capture_bank #(
        .CHANNELS   (CH),
        .SYNC_STAGES(2),
        .FILTER_BITS(FB),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .resn        (resn),
        .in_i        (in_v),
        .mode_i      (mode),
        .filter_len_i(flen),
        .pend_clr_i  (pend_clr),
        .cnt_clr_i   (cnt_clr),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .level_o     (level_o),
        .pending_o   (pending_o),
        .count_o     (count_o),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] cnt(input int n);
        logic [CH*CW-1:0] sh;
        sh = count_o >> (n * CW);
        return 32'(sh[CW-1:0]);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Input driven after edge cyc: pulse registered at cyc + 1 + SYNC_STAGES + flen.
    task automatic expect_pulse(input logic [CH-1:0] r, input logic [CH-1:0] f);
        exp_t e;
        e.cyc  = cyc + 3 + int'(flen);
        e.rise = r;
        e.fall = f;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if ((rise_o | fall_o) != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: rise %b fall %b at cycle %0d", rise_o, fall_o,
                         cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_rise", 32'(rise_o), 32'(e.rise));
                check("pulse_fall", 32'(fall_o), 32'(e.fall));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rise"}, 32'(rise_o), 0);
        check({tag, "_fall"}, 32'(fall_o), 0);
        check({tag, "_level"}, 32'(level_o), 0);
        check({tag, "_pending"}, 32'(pending_o), 0);
        check({tag, "_count"}, 32'(count_o), 0);
        check({tag, "_irq"}, 32'(irq_o), 0);
    endtask

    initial begin
        resn = 1'b0; in_v = '0; mode = '0; flen = '0; pend_clr = '0; cnt_clr = '0;
        step(3);
        check_all_zero("reset");
        resn = 1'b1;
        step(3);

        // Channel 0, rise mode, no filtering.
        mode[1:0] = 2'b01;
        in_v[0] = 1'b1;
        expect_pulse(4'b0001, 4'b0000);
        step(3);
        check("ch0_pending", 32'(pending_o[0]), 1);
        check("ch0_count", cnt(0), 1);
        check("ch0_irq", 32'(irq_o), 1);
        check("ch0_level", 32'(level_o[0]), 1);
        step(2);

        // Channel 1, filter length 3: 3-cycle glitch rejected, 5-cycle pulse accepted.
        flen = 4'd3;
        mode[3:2] = 2'b01;
        in_v[1] = 1'b1;
        step(3);
        in_v[1] = 1'b0;
        step(10);
        check("glitch_count", cnt(1), 0);
        check("glitch_level", 32'(level_o[1]), 0);
        check("glitch_pending", 32'(pending_o[1]), 0);
        in_v[1] = 1'b1;
        expect_pulse(4'b0010, 4'b0000);
        step(5);
        in_v[1] = 1'b0;
        expect_pulse(4'b0000, 4'b0010);
        step(12);
        check("ch1_count", cnt(1), 1);
        check("ch1_level", 32'(level_o[1]), 0);

        // Channel 2, fall-only mode.
        flen = 4'd0;
        mode[5:4] = 2'b10;
        in_v[2] = 1'b1;
        expect_pulse(4'b0100, 4'b0000);
        step(3);
        check("ch2_pend_after_rise", 32'(pending_o[2]), 0);
        check("ch2_count_after_rise", cnt(2), 0);
        in_v[2] = 1'b0;
        expect_pulse(4'b0000, 4'b0100);
        step(3);
        check("ch2_pend_after_fall", 32'(pending_o[2]), 1);
        check("ch2_count_after_fall", cnt(2), 1);
        step(2);

        // Channel 3, both edges, 20 edges saturate a 4-bit counter.
        mode[7:6] = 2'b11;
        for (int i = 0; i < 20; i++) begin
            in_v[3] = ~in_v[3];
            if (in_v[3]) expect_pulse(4'b1000, 4'b0000);
            else         expect_pulse(4'b0000, 4'b1000);
            step(2);
        end
        step(4);
        check("ch3_saturated", cnt(3), 15);

        // Clear all pending flags; irq follows in the same cycle.
        pend_clr = '1;
        step(1);
        pend_clr = '0;
        check("pend_clr_pending", 32'(pending_o), 0);
        check("pend_clr_irq", 32'(irq_o), 0);

        // Channel 0: clears coincident with a qualified rise.
        in_v[0] = 1'b0;
        expect_pulse(4'b0000, 4'b0001);
        step(3);
        in_v[0] = 1'b1;
        expect_pulse(4'b0001, 4'b0000);
        step(2);
        cnt_clr[0] = 1'b1;
        pend_clr[0] = 1'b1;
        step(1);
        cnt_clr[0] = 1'b0;
        pend_clr[0] = 1'b0;
        check("clr_ev_count", cnt(0), 1);
        check("clr_ev_pending", 32'(pending_o[0]), 1);
        cnt_clr[0] = 1'b1;
        step(1);
        cnt_clr[0] = 1'b0;
        check("cnt_clr_alone", cnt(0), 0);

        // Reset mid filter-count with inputs held high.
        flen = 4'd5;
        in_v[1] = 1'b1;
        step(4);
        resn = 1'b0;
        step(2);
        check_all_zero("midreset");
        resn = 1'b1;
        expect_pulse(4'b0011, 4'b0000);
        step(12);
        check("post_reset_level", 32'(level_o), 32'h3);
        check("post_reset_count1", cnt(1), 1);
        check("post_reset_irq", 32'(irq_o), 1);

        step(5);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
